// File: rtl/mux_reg_arbiter_if.sv
// Request/grant/data bundle between requesters and the shared-register arbiter.
// q_par exists only when MUXREG_PARITY_EN is defined.
interface mux_reg_arbiter_if #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
);
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] wdata;
   logic [NREQ-1:0]       sel;
   logic [NREQ-1:0]       ack;
   logic [WIDTH-1:0]      q;
   logic [2:0]            owner;
   logic                  busy;
`ifdef MUXREG_PARITY_EN
   logic                  q_par;

   modport master (output req, wdata, input sel, ack, q, owner, busy, q_par);
   modport slave  (input req, wdata, output sel, ack, q, owner, busy, q_par);
`else
   modport master (output req, wdata, input sel, ack, q, owner, busy);
   modport slave  (input req, wdata, output sel, ack, q, owner, busy);
`endif
endinterface

// File: rtl/mux_reg_arbiter.sv
// Round-robin arbiter writing one shared register; IDLE->GRANT->LOAD->ACK, q updates 2 edges after req.
// One write in flight, no backpressure beyond req holding; MUXREG_PARITY_EN adds registered odd parity q_par.
module mux_reg_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   mux_reg_arbiter_if.slave  bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GRANT = 2'd1;
   localparam logic [1:0] LOAD  = 2'd2;
   localparam logic [1:0] ACK   = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [NREQ-1:0]  sel_q, sel_d;
   logic [NREQ-1:0]  ack_q, ack_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [2:0]       owner_q, owner_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [2:0]       win_q, win_d;

   logic [7:0]       req8;
   logic             win_found;
   logic [2:0]       win_idx;
   logic [2:0]       idx;
   logic [WIDTH-1:0] slot;

   // Zero-extended so any 3-bit index is in range for every legal NREQ.
   assign req8 = 8'(bus.req);

   // Search starts just after the last completed winner and wraps modulo NREQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      idx       = '0;
      for (int off = 1; off <= NREQ; off++) begin
         idx = 3'((int'(ptr_q) + off) % NREQ);
         if (!win_found && req8[idx]) begin
            win_found = 1'b1;
            win_idx   = idx;
         end
      end
   end

   always_comb begin
      slot = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (3'(i) == win_q) slot = bus.wdata[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ack_d   = '0;
      q_d     = q_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = GRANT;
               sel_d   = NREQ'(1) << win_idx;
               win_d   = win_idx;
            end
         end
         GRANT: begin
            if (req8[win_q]) begin
               state_d = LOAD;
            end else begin
               state_d = IDLE;
               sel_d   = '0;
            end
         end
         LOAD: begin
            state_d = ACK;
            q_d     = slot;
            owner_d = win_q;
            ptr_d   = win_q;
            ack_d   = sel_q;
            sel_d   = '0;
         end
         default: begin
            state_d = IDLE;
            sel_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
         ack_q   <= '0;
         q_q     <= '0;
         owner_q <= '0;
         ptr_q   <= 3'(NREQ - 1);
         win_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ack_q   <= ack_d;
         q_q     <= q_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
      end
   end

   assign bus.sel   = sel_q;
   assign bus.ack   = ack_q;
   assign bus.q     = q_q;
   assign bus.owner = owner_q;
   assign bus.busy  = (state_q != IDLE);

`ifdef MUXREG_PARITY_EN
   logic q_par_q;

   // Odd parity: q_par makes the total count of ones across {q, q_par} odd.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             q_par_q <= 1'b1;
      else if (state_q == LOAD) q_par_q <= ~^slot;
   end

   assign bus.q_par = q_par_q;
`endif

endmodule

// File: doc/mux_reg_arbiter.md
MUX_REG_ARBITER -- requirements
Module: mux_reg_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, width of the shared register and of each write-data slot.
REQ-002 Parameter NREQ, default 4, number of requesters; legal range 2..8.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  NREQ  per-requester write request; bit i belongs to requester i.
REQ-006 wdata  input  NREQ*WIDTH  per-requester write data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 sel  output  NREQ  registered one-hot mux select to the shared register datapath; all-zero when no grant is active.
REQ-008 ack  output  NREQ  one-hot, single-cycle write-complete pulse.
REQ-009 q  output  WIDTH  current shared register contents.
REQ-010 owner  output  3  index of the requester that last wrote q.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, GRANT, LOAD and ACK.
REQ-013 IDLE: if any req bit is high at a clock edge, the FSM SHALL pick the winner round-robin, set sel to the winner's one-hot code and go to GRANT; otherwise it SHALL stay in IDLE with sel=0.
REQ-014 Round-robin: the search SHALL start at index ptr+1, wrap modulo NREQ, and pick the first asserted req; ptr is the last completed winner.
REQ-015 GRANT: if req[winner] is still high, the FSM SHALL go to LOAD; if it has dropped, it SHALL abort to IDLE with sel=0, no write, no ack and ptr unchanged.
REQ-016 LOAD: at the exiting edge, q SHALL load wdata slot[winner], owner SHALL load winner, ptr SHALL load winner, and the FSM SHALL go to ACK.
REQ-017 ACK: ack[winner] SHALL be high for exactly this one cycle, sel SHALL be 0, and the next state SHALL be IDLE unconditionally.
REQ-018 Latency: with req sampled at edge k, q SHALL update at edge k+2, and ack SHALL be high between edges k+2 and k+3.
REQ-019 A new grant SHALL take at least 4 cycles (IDLE, GRANT, LOAD, ACK); at most one write SHALL be in flight.
REQ-020 If a requester's req is still high in the IDLE cycle after its ack, it SHALL count as a new request and SHALL lose to any other pending requester.
REQ-021 req changes on non-winning bits during GRANT, LOAD or ACK SHALL have no effect until the next IDLE.
REQ-022 q SHALL change only at the LOAD exit edge or at reset.
REQ-023 wdata SHALL be sampled only at the LOAD exit edge.

Reset
REQ-024 Asserting rst_n low SHALL immediately force the state to IDLE and set q=0, owner=0, sel=0, ack=0, busy=0 and ptr=NREQ-1, so requester 0 wins first.
REQ-025 A reset during GRANT, LOAD or ACK SHALL discard the operation, with no ack issued after reset release.

Configuration
REQ-026 Macro MUXREG_PARITY_EN: when defined, the block SHALL add an output port q_par (1 bit) holding the registered odd parity of q, with reset value 1, updated at the same edge as q.
REQ-027 Without MUXREG_PARITY_EN, the q_par port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-028 Single requester: after reset, req=4'b0100 and slot2=8'hA5 held -> sel=4'b0100 in GRANT, q=8'hA5 at k+2, ack=4'b0100 for one cycle, owner=2.
REQ-029 Round-robin fairness: req=4'b1111 held continuously -> ack order 0,1,2,3,0 at 4-cycle spacing; q follows each slot's value.
REQ-030 Abort: req[1] raised and then dropped during GRANT -> no ack, q unchanged, the next grant search still starts from the previous ptr+1.
REQ-031 Reset mid-op: rst_n pulled low during LOAD -> q=0, busy=0, no ack after release; the first grant afterwards goes to requester 0 if it is requesting.
REQ-032 Wrap and parity: ptr=3 and req=4'b1001 -> requester 0 is granted; with MUXREG_PARITY_EN defined and q=8'h07, q_par=0.
